// File: rtl/ccc_cfg_pkg.sv
// Shared definitions for the CCC dynamic-configuration controller: FSM states,
// default word length and lock-wait constants, and a counter-width helper.
package ccc_cfg_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      SHIFT     = 3'd1,
      GAP       = 3'd2,
      UPDATE    = 3'd3,
      WAIT_LOCK = 3'd4,
      DONE      = 3'd5
   } ccc_cfg_state_e;

   localparam int unsigned CCC_CFG_BITS     = 81;
   localparam int unsigned CCC_SCLK_DIV     = 2;
   localparam int unsigned CCC_LOCK_TIMEOUT = 4096;
   localparam int unsigned CCC_LOCK_BLANK   = 16;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int unsigned ccc_cnt_width(input int unsigned n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop level synchroniser for a single asynchronous input.
// Synchronous active-low reset clears both stages.
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/ccc_dyncfg_ctrl.sv
// Run-time CCC reprogramming: shifts a config word out serially, strobes update,
// waits for PLL lock with timeout. Build option CCC_CFG_READBACK_EN adds SDOUT capture.
//
// state     | meaning
// IDLE      | waiting for CFG_START
// SHIFT     | clocking CFG_BITS bits out on SCLK/SDIN, LSB first
// GAP       | one idle bit period before the update strobe
// UPDATE    | SUPDATE held for one bit period
// WAIT_LOCK | lock timer running; LOCK blanked, then checked against timeout
// DONE      | single-cycle completion pulse with error flag
module ccc_dyncfg_ctrl
   import ccc_cfg_pkg::*;
#(
   parameter int unsigned CFG_BITS     = CCC_CFG_BITS,
   parameter int unsigned SCLK_DIV     = CCC_SCLK_DIV,
   parameter int unsigned LOCK_TIMEOUT = CCC_LOCK_TIMEOUT,
   parameter int unsigned LOCK_BLANK   = CCC_LOCK_BLANK
) (
   input  logic                FAB_CLK,
   input  logic                M2F_RESET_N,
   input  logic                CFG_START,
   input  logic [CFG_BITS-1:0] CFG_WORD,
   output logic                CFG_BUSY,
   output logic                CFG_DONE,
   output logic                CFG_ERR,
   input  logic                LOCK,
   output logic                SCLK,
   output logic                SSHIFT,
   output logic                SDIN,
   output logic                SUPDATE,
   output logic                MODE
`ifdef CCC_CFG_READBACK_EN
   ,
   input  logic                SDOUT,
   output logic [CFG_BITS-1:0] RDBK_WORD
`endif
);

   localparam int unsigned PH_W  = ccc_cnt_width(2 * SCLK_DIV);
   localparam int unsigned BIT_W = ccc_cnt_width(CFG_BITS);
   localparam int unsigned TMR_W = ccc_cnt_width(LOCK_TIMEOUT + LOCK_BLANK + 1);

   localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(2 * SCLK_DIV - 1);
   localparam logic [PH_W-1:0]  PH_HIGH   = PH_W'(SCLK_DIV);
   localparam logic [PH_W-1:0]  PH_ONE    = PH_W'(1);
   localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(CFG_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam logic [TMR_W-1:0] TMR_BLANK = TMR_W'(LOCK_BLANK);
   localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

   ccc_cfg_state_e      r_state;
   ccc_cfg_state_e      w_state_nxt;
   logic [PH_W-1:0]     r_phase;
   logic [PH_W-1:0]     w_phase_nxt;
   logic [BIT_W-1:0]    r_bit;
   logic [BIT_W-1:0]    w_bit_nxt;
   logic [TMR_W-1:0]    r_timer;
   logic [TMR_W-1:0]    w_timer_nxt;
   logic [CFG_BITS-1:0] r_sreg;
   logic [CFG_BITS-1:0] w_sreg_nxt;
   logic                r_err;
   logic                w_err_nxt;

   logic                r_busy;
   logic                r_done;
   logic                r_sclk;
   logic                r_sshift;
   logic                r_sdin;
   logic                r_supdate;
   logic                r_mode;

   logic                w_lock_sync;
   logic                w_phase_last;
   logic                w_shift_nxt;

   sync_2ff u_lock_sync (
      .i_clk   (FAB_CLK),
      .i_rst_n (M2F_RESET_N),
      .i_d     (LOCK),
      .o_q     (w_lock_sync)
   );

   assign w_phase_last = (r_phase == PH_LAST);
   assign w_shift_nxt  = (w_state_nxt == SHIFT);

   always_comb begin
      w_state_nxt = r_state;
      w_phase_nxt = r_phase;
      w_bit_nxt   = r_bit;
      w_timer_nxt = r_timer;
      w_sreg_nxt  = r_sreg;
      w_err_nxt   = r_err;

      unique case (r_state)
         IDLE: begin
            if (CFG_START) begin
               w_state_nxt = SHIFT;
               w_phase_nxt = '0;
               w_bit_nxt   = '0;
               w_sreg_nxt  = CFG_WORD;
               w_err_nxt   = 1'b0;
            end
         end

         SHIFT: begin
            if (w_phase_last) begin
               w_phase_nxt = '0;
               w_sreg_nxt  = r_sreg >> 1;
               if (r_bit == BIT_LAST) begin
                  w_state_nxt = GAP;
               end else begin
                  w_bit_nxt = r_bit + BIT_ONE;
               end
            end else begin
               w_phase_nxt = r_phase + PH_ONE;
            end
         end

         GAP: begin
            if (w_phase_last) begin
               w_phase_nxt = '0;
               w_state_nxt = UPDATE;
            end else begin
               w_phase_nxt = r_phase + PH_ONE;
            end
         end

         UPDATE: begin
            if (w_phase_last) begin
               w_phase_nxt = '0;
               w_timer_nxt = '0;
               w_state_nxt = WAIT_LOCK;
            end else begin
               w_phase_nxt = r_phase + PH_ONE;
            end
         end

         WAIT_LOCK: begin
            // Lock is tested first so a lock on the final timer cycle still succeeds.
            if ((r_timer >= TMR_BLANK) && w_lock_sync) begin
               w_state_nxt = DONE;
               w_err_nxt   = 1'b0;
            end else if (r_timer == TMR_LAST) begin
               w_state_nxt = DONE;
               w_err_nxt   = 1'b1;
            end else begin
               w_timer_nxt = r_timer + TMR_ONE;
            end
         end

         DONE: begin
            w_state_nxt = IDLE;
         end

         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   // Pin outputs are decoded from the next state so they leave straight from flops.
   always_ff @(posedge FAB_CLK) begin
      if (!M2F_RESET_N) begin
         r_state   <= IDLE;
         r_phase   <= '0;
         r_bit     <= '0;
         r_timer   <= '0;
         r_sreg    <= '0;
         r_err     <= 1'b0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_sclk    <= 1'b0;
         r_sshift  <= 1'b0;
         r_sdin    <= 1'b0;
         r_supdate <= 1'b0;
         r_mode    <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_phase   <= w_phase_nxt;
         r_bit     <= w_bit_nxt;
         r_timer   <= w_timer_nxt;
         r_sreg    <= w_sreg_nxt;
         r_err     <= w_err_nxt;
         r_busy    <= (w_state_nxt != IDLE) && (w_state_nxt != DONE);
         r_done    <= (w_state_nxt == DONE);
         r_sclk    <= w_shift_nxt && (w_phase_nxt >= PH_HIGH);
         r_sshift  <= w_shift_nxt;
         r_sdin    <= w_shift_nxt && w_sreg_nxt[0];
         r_supdate <= (w_state_nxt == UPDATE);
         r_mode    <= r_mode || w_shift_nxt;
      end
   end

   assign CFG_BUSY = r_busy;
   assign CFG_DONE = r_done;
   assign CFG_ERR  = r_err;
   assign SCLK     = r_sclk;
   assign SSHIFT   = r_sshift;
   assign SDIN     = r_sdin;
   assign SUPDATE  = r_supdate;
   assign MODE     = r_mode;

`ifdef CCC_CFG_READBACK_EN
   localparam logic [PH_W-1:0] PH_RISE = PH_W'(SCLK_DIV - 1);

   logic [CFG_BITS-1:0] r_rdbk_sreg;
   logic [CFG_BITS-1:0] r_rdbk_word;

   // SDOUT is taken on the edge that raises SCLK; the old config arrives LSB first.
   always_ff @(posedge FAB_CLK) begin
      if (!M2F_RESET_N) begin
         r_rdbk_sreg <= '0;
         r_rdbk_word <= '0;
      end else begin
         if ((r_state == SHIFT) && (r_phase == PH_RISE)) begin
            r_rdbk_sreg <= {SDOUT, r_rdbk_sreg[CFG_BITS-1:1]};
         end
         if ((r_state == SHIFT) && (w_state_nxt == GAP)) begin
            r_rdbk_word <= r_rdbk_sreg;
         end
      end
   end

   assign RDBK_WORD = r_rdbk_word;
`endif

endmodule

// File: tb/tb_ccc_dyncfg_ctrl.sv
// Scoreboard bench for ccc_dyncfg_ctrl: stimulus pushes expected completions computed
// from a closed-form timing model; a negedge monitor pops and compares on CFG_DONE.
module tb_ccc_dyncfg_ctrl;

   localparam int CFG_BITS     = 81;
   localparam int SCLK_DIV     = 2;
   localparam int LOCK_TIMEOUT = 4096;
   localparam int LOCK_BLANK   = 16;
   localparam int BIT_CYC      = 2 * SCLK_DIV;
   localparam int WL_OFS       = (CFG_BITS + 2) * BIT_CYC;

   localparam int LK_NEVER = 0;
   localparam int LK_HELD  = 1;
   localparam int LK_DELAY = 2;

   logic                FAB_CLK     = 1'b0;
   logic                M2F_RESET_N = 1'b0;
   logic                CFG_START   = 1'b0;
   logic [CFG_BITS-1:0] CFG_WORD    = '0;
   logic                LOCK        = 1'b0;
   logic                CFG_BUSY;
   logic                CFG_DONE;
   logic                CFG_ERR;
   logic                SCLK;
   logic                SSHIFT;
   logic                SDIN;
   logic                SUPDATE;
   logic                MODE;
`ifdef CCC_CFG_READBACK_EN
   logic                SDOUT;
   logic [CFG_BITS-1:0] RDBK_WORD;
   logic [CFG_BITS-1:0] rb_model = '0;
`endif

   typedef struct {
      int                  done_cyc;
      logic                err;
      logic [CFG_BITS-1:0] word;
   } exp_t;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   cyc     = 0;

   ccc_dyncfg_ctrl #(
      .CFG_BITS     (CFG_BITS),
      .SCLK_DIV     (SCLK_DIV),
      .LOCK_TIMEOUT (LOCK_TIMEOUT),
      .LOCK_BLANK   (LOCK_BLANK)
   ) dut (
      .FAB_CLK     (FAB_CLK),
      .M2F_RESET_N (M2F_RESET_N),
      .CFG_START   (CFG_START),
      .CFG_WORD    (CFG_WORD),
      .CFG_BUSY    (CFG_BUSY),
      .CFG_DONE    (CFG_DONE),
      .CFG_ERR     (CFG_ERR),
      .LOCK        (LOCK),
      .SCLK        (SCLK),
      .SSHIFT      (SSHIFT),
      .SDIN        (SDIN),
      .SUPDATE     (SUPDATE),
      .MODE        (MODE)
`ifdef CCC_CFG_READBACK_EN
      ,
      .SDOUT       (SDOUT),
      .RDBK_WORD   (RDBK_WORD)
`endif
   );

   always #5 FAB_CLK = ~FAB_CLK;

   // cyc, read at a negedge, is the index of the posedge just taken.
   always @(posedge FAB_CLK) cyc <= cyc + 1;

   initial begin
      #1000000;
      $display("FAIL watchdog: run exceeded time limit at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) @(negedge FAB_CLK);
   endtask

   function automatic logic [CFG_BITS-1:0] rand_word();
      logic [95:0] t;
      t = {$urandom(), $urandom(), $urandom()};
      return t[CFG_BITS-1:0];
   endfunction

   // Start taken at edge s_edge; WAIT_LOCK begins WL_OFS edges later. Lock driven high
   // before edge l_edge+1 is visible after synchronisation from edge l_edge+2. The first
   // cycle both visible and past blanking decides success, otherwise the timer expires.
   function automatic exp_t model(input logic [CFG_BITS-1:0] word, input int s_edge,
                                  input int l_edge);
      exp_t e;
      int   we;
      int   seen;
      we         = s_edge + WL_OFS;
      e.word     = word;
      e.err      = 1'b1;
      e.done_cyc = we + LOCK_TIMEOUT;
      if (l_edge >= 0) begin
         seen = (l_edge + 2 > we + LOCK_BLANK) ? l_edge + 2 : we + LOCK_BLANK;
         if (seen < we + LOCK_TIMEOUT) begin
            e.err      = 1'b0;
            e.done_cyc = seen + 1;
         end
      end
      return e;
   endfunction

   task automatic run_txn(input logic [CFG_BITS-1:0] word, input int lock_mode,
                          input int lock_dly, input bit poke40, input logic prev_err);
      int   s_edge;
      int   l_edge;
      exp_t e;
      logic [CFG_BITS-1:0] w;
      w = word;
      @(negedge FAB_CLK);
      check("err_held_idle", 128'(CFG_ERR), 128'(prev_err));
      l_edge = -1;
      if (lock_mode == LK_HELD) begin
         LOCK   = 1'b1;
         l_edge = cyc;
         repeat (3) @(negedge FAB_CLK);
      end
      CFG_WORD  = w;
      CFG_START = 1'b1;
      s_edge    = cyc + 1;
      if (lock_mode == LK_DELAY) l_edge = s_edge + WL_OFS + lock_dly;
      e = model(w, s_edge, l_edge);
      exp_q.push_back(e);
      @(negedge FAB_CLK);
      CFG_START = 1'b0;
      CFG_WORD  = ~w;
      check("start_outputs", 128'({CFG_BUSY, SSHIFT, MODE, SCLK, CFG_ERR, SDIN}),
            128'({4'b1110, 1'b0, w[0]}));
      if (poke40) begin
         wait_until(s_edge + 40 * BIT_CYC + 1);
         CFG_WORD  = rand_word();
         CFG_START = 1'b1;
         @(negedge FAB_CLK);
         CFG_START = 1'b0;
      end
      if (lock_mode == LK_DELAY) begin
         wait_until(l_edge);
         LOCK = 1'b1;
      end
      wait_until(e.done_cyc + 2);
      check("done_seen", 128'(exp_q.size()), 128'(0));
      exp_q.delete();
      check("err_after_done", 128'(CFG_ERR), 128'(e.err));
      LOCK = 1'b0;
      repeat (6) @(negedge FAB_CLK);
   endtask

   initial begin : monitor
      exp_t                e;
      logic                prev_sclk;
      logic                prev_sshift;
      logic                prev_sdin;
      int                  cap_n;
      int                  upd_len;
      logic [CFG_BITS-1:0] cap_word;
      prev_sclk   = 1'b0;
      prev_sshift = 1'b0;
      prev_sdin   = 1'b0;
      cap_n       = 0;
      upd_len     = 0;
      cap_word    = '0;
`ifdef CCC_CFG_READBACK_EN
      SDOUT = 1'b0;
`endif
      forever begin
         @(negedge FAB_CLK);
         if (SSHIFT && !prev_sshift) begin
            cap_n    = 0;
            upd_len  = 0;
            cap_word = '0;
         end
         if (SSHIFT && (SDIN !== prev_sdin)) check("sdin_change_sclk_low", 128'(SCLK), 128'(0));
         if (SCLK && !prev_sclk) begin
            if (cap_n < CFG_BITS) cap_word[cap_n] = SDIN;
            cap_n++;
         end
`ifdef CCC_CFG_READBACK_EN
         SDOUT = (cap_n < CFG_BITS) ? rb_model[cap_n] : 1'b0;
`endif
         if (SUPDATE) begin
            upd_len++;
            check("update_pins", 128'({SSHIFT, SCLK, SDIN, MODE}), 128'(4'b0001));
         end
         if (CFG_DONE) begin
            if (exp_q.size() == 0) begin
               check("unexpected_done", 128'(CFG_DONE), 128'(0));
            end else begin
               e = exp_q.pop_front();
               check("done_cycle", 128'(cyc), 128'(e.done_cyc));
               check("done_err", 128'(CFG_ERR), 128'(e.err));
               check("done_busy_low", 128'(CFG_BUSY), 128'(0));
               check("shifted_word", 128'(cap_word), 128'(e.word));
               check("sclk_rises", 128'(cap_n), 128'(CFG_BITS));
               check("supdate_len", 128'(upd_len), 128'(BIT_CYC));
            end
         end
         prev_sclk   = SCLK;
         prev_sshift = SSHIFT;
         prev_sdin   = SDIN;
      end
   end

   initial begin : stimulus
      int s_edge;
      int mode;
      logic last_err;

      repeat (3) @(negedge FAB_CLK);
      check("reset_outputs", 128'({SCLK, SSHIFT, SDIN, SUPDATE, MODE, CFG_BUSY, CFG_DONE, CFG_ERR}),
            128'(0));
`ifdef CCC_CFG_READBACK_EN
      check("reset_rdbk", 128'(RDBK_WORD), 128'(0));
`endif
      M2F_RESET_N = 1'b1;
      repeat (3) @(negedge FAB_CLK);

      run_txn(81'h1_5555_5555_5555_5555_5555, LK_DELAY, 100, 1'b0, 1'b0);
      run_txn(rand_word(), LK_NEVER, 0, 1'b0, 1'b0);
      run_txn(rand_word(), LK_HELD, 0, 1'b0, 1'b1);
      run_txn(rand_word(), LK_DELAY, 40, 1'b1, 1'b0);
      run_txn(rand_word(), LK_DELAY, LOCK_TIMEOUT - 3, 1'b0, 1'b0);
      run_txn(rand_word(), LK_DELAY, LOCK_TIMEOUT - 2, 1'b0, 1'b0);
      last_err = 1'b1;

      // Reset in the middle of shifting bit 20.
      @(negedge FAB_CLK);
      CFG_WORD  = rand_word();
      CFG_START = 1'b1;
      s_edge    = cyc + 1;
      @(negedge FAB_CLK);
      CFG_START = 1'b0;
      wait_until(s_edge + 20 * BIT_CYC + 1);
      M2F_RESET_N = 1'b0;
      @(negedge FAB_CLK);
      check("midreset_outputs",
            128'({SCLK, SSHIFT, SDIN, SUPDATE, MODE, CFG_BUSY, CFG_DONE, CFG_ERR}), 128'(0));
`ifdef CCC_CFG_READBACK_EN
      check("midreset_rdbk", 128'(RDBK_WORD), 128'(0));
`endif
      @(negedge FAB_CLK);
      M2F_RESET_N = 1'b1;
      repeat (WL_OFS + 40) @(negedge FAB_CLK);
      check("idle_after_reset", 128'({CFG_BUSY, SSHIFT, MODE}), 128'(0));
      last_err = 1'b0;

`ifdef CCC_CFG_READBACK_EN
      rb_model = 81'h0_ABCD;
      run_txn(rand_word(), LK_DELAY, 10, 1'b0, last_err);
      check("rdbk_word", 128'(RDBK_WORD), 128'(81'h0_ABCD));
`endif

      for (int i = 0; i < 6; i++) begin
         mode = ($urandom_range(0, 3) == 0) ? LK_HELD : LK_DELAY;
`ifdef CCC_CFG_READBACK_EN
         rb_model = rand_word();
`endif
         run_txn(rand_word(), mode, $urandom_range(0, 250), 1'($urandom_range(0, 1)), 1'b0);
`ifdef CCC_CFG_READBACK_EN
         check("rdbk_word_rand", 128'(RDBK_WORD), 128'(rb_model));
`endif
      end

      repeat (20) @(negedge FAB_CLK);
      check("queue_empty_end", 128'(exp_q.size()), 128'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ccc_dyncfg_ctrl.md
# ccc_dyncfg_ctrl

Fabric-side controller that reprograms the MSS clock-conditioning circuit (CCC) at run time through its serial dynamic-configuration port. A requester hands it a full CCC configuration word. The block serially shifts the word into the CCC, pulses the update strobe, and waits for PLL lock with a timeout. It runs on the fabric clock the CCC already provides and reports completion or lock failure to the system controller logic.

## Interface
- `CFG_BITS`, default 81: length of the CCC dynamic-configuration word.
- `SCLK_DIV`, default 2: `FAB_CLK` cycles per `SCLK` half-period; legal range ≥1.
- `LOCK_TIMEOUT`, default 4096: `FAB_CLK` cycles allowed for lock after update.
- `LOCK_BLANK`, default 16: initial `WAIT_LOCK` cycles during which `LOCK` is ignored.
- `FAB_CLK`, in, 1: the block's only clock.
- `M2F_RESET_N`, in, 1: reset, synchronous and active-low.
- `CFG_START`, in, 1: one-cycle request to start programming.
- `CFG_WORD`, in, `CFG_BITS`: configuration word; sampled on an accepted start.
- `CFG_BUSY`, out, 1: high from an accepted start until `CFG_DONE`.
- `CFG_DONE`, out, 1: one-cycle completion pulse.
- `CFG_ERR`, out, 1: valid with `CFG_DONE`; 1 means lock timed out.
- `LOCK`, in, 1: CCC lock indication; asynchronous to the block, double-flop synchronised internally.
- `SCLK`, out, 1: serial config clock to the CCC.
- `SSHIFT`, out, 1: shift enable to the CCC.
- `SDIN`, out, 1: serial config data to the CCC.
- `SUPDATE`, out, 1: update strobe to the CCC.
- `MODE`, out, 1: selects the dynamic configuration over the flash configuration.
- `SDOUT`, in, 1: serial readback data. Used only with `CCC_CFG_READBACK_EN`.
- `RDBK_WORD`, out, `CFG_BITS`: captured previous config. Present only with `CCC_CFG_READBACK_EN`.

## Operation
- **Reset values:** all outputs are 0 (`SCLK`, `SSHIFT`, `SDIN`, `SUPDATE`, `MODE`, `CFG_BUSY`, `CFG_DONE`, `CFG_ERR`, `RDBK_WORD`). The FSM enters `IDLE`.
- **IDLE:**
  - `CFG_START`=1 latches `CFG_WORD` into the shift register, clears the bit counter, and moves to `SHIFT`.
  - `CFG_START` while not in `IDLE` is ignored; the request is dropped, not queued.
- **SHIFT:**
  - `MODE`=1 and `SSHIFT`=1 for the whole state.
  - Each bit period lasts 2·`SCLK_DIV` cycles: `SCLK` low for `SCLK_DIV` cycles, then high for `SCLK_DIV` cycles.
  - `SDIN` is the shift-register LSB and changes only at the start of a bit period, while `SCLK` is low. Data goes out LSB first.
  - The register shifts right at the end of each period. After `CFG_BITS` periods the FSM moves to `GAP`.
- **GAP:** `SSHIFT`=0, `SCLK`=0, `SDIN`=0 for 2·`SCLK_DIV` cycles, then `UPDATE`.
- **UPDATE:** `SUPDATE`=1 for 2·`SCLK_DIV` cycles, then `WAIT_LOCK`. `MODE` stays 1 from here on, until reset.
- **WAIT_LOCK:**
  - A counter runs from 0.
  - For the first `LOCK_BLANK` cycles the synchronised `LOCK` is ignored, because the old lock may still read high.
  - After that, synchronised `LOCK`=1 moves to `DONE` with err=0.
  - A count reaching `LOCK_TIMEOUT`−1 moves to `DONE` with err=1.
  - If both occur in the same cycle, lock wins (err=0).
- **DONE:** one cycle with `CFG_DONE`=1, `CFG_ERR`=err, `CFG_BUSY`=0, then `IDLE`. `CFG_ERR` holds its value until the next accepted start clears it.
- **Reset mid-operation:** all outputs return to their reset values on the reset edge and no `CFG_DONE` is produced. The CCC keeps whatever it last latched on `SUPDATE`.

## Timing
- `CFG_BUSY` rises the cycle after the `CFG_START` sample; the first `SCLK` low half begins that same cycle.
- Start to `WAIT_LOCK` entry is (`CFG_BITS`+2)·2·`SCLK_DIV` cycles. With defaults that is 332 cycles.
- `CFG_DONE` follows lock detection by 1 cycle, plus 2 cycles of synchroniser latency after `LOCK` rises.
- `SCLK` frequency is `FAB_CLK`/(2·`SCLK_DIV`).
- All outputs are registered.

## Configuration
- `CCC_CFG_READBACK_EN` defined:
  - `SDOUT` is sampled on each `SCLK` rising phase (the last cycle before `SCLK` goes high) and shifted into a readback register, LSB first.
  - `RDBK_WORD` updates on entry to `GAP` and holds until the next one.
- `CCC_CFG_READBACK_EN` undefined: the `SDOUT` and `RDBK_WORD` ports and the readback register are removed entirely.

## Structure
- Shared package `ccc_cfg_pkg`: FSM state enum (`IDLE`, `SHIFT`, `GAP`, `UPDATE`, `WAIT_LOCK`, `DONE`), `CCC_CFG_BITS`=81, and the default timeout and blank constants.
- One sub-module, `sync_2ff`, the `LOCK` synchroniser; reusable elsewhere.
- Everything else is a single FSM plus three counters: phase, bit, and lock timer.

## Test plan
- `CFG_WORD`=81'h1_5555…5555 (alternating ones and zeros), defaults, `LOCK` rising 100 cycles after `SUPDATE` falls → `SDIN` alternates 1,0,… each 4 cycles; 81 `SCLK` rises; `SUPDATE` lasts 4 cycles; `CFG_DONE`=1 with `CFG_ERR`=0.
- `LOCK` held at 0 → `CFG_DONE` with `CFG_ERR`=1 exactly 4096 cycles after `WAIT_LOCK` entry.
- `LOCK` held at 1 throughout → no completion before `LOCK_BLANK`; `CFG_DONE` at blank end + 1, err=0.
- `CFG_START` pulsed at shift bit 40 → ignored; the shifted word is unchanged and exactly one `CFG_DONE` is produced.
- `M2F_RESET_N` low at bit 20 → next cycle all outputs are 0 and the FSM is in `IDLE`; no `CFG_DONE`.
- With `CCC_CFG_READBACK_EN` and `SDOUT` driven from an 81-bit model holding 81'h0_ABCD → `RDBK_WORD`=81'h0_ABCD at `GAP` entry.
